// File: rtl/weight_bank.sv
// Weight storage for a small two-layer network: DEPTH signed words with
// single-port style write/read access and an LFSR-driven random fill.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | external reads and writes accepted; waiting for init_start
// FILL  | one LFSR word written per cycle to 0..DEPTH-1; accesses dropped
module weight_bank #(
    parameter int          WIDTH = 10,
    parameter int          N_IN  = 30,
    parameter int          N_HID = 5,
    parameter int          N_OUT = 3,
    parameter logic [15:0] SEED  = 16'hACE1,
    localparam int         DEPTH = N_IN * N_HID + N_HID * N_OUT,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_start,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic signed [WIDTH-1:0] wdata,
    input  logic                    re,
    input  logic [AW-1:0]           raddr,
    output logic signed [WIDTH-1:0] rdata,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    init_done,
    output logic                    drop_err
);

    typedef enum logic {IDLE, FILL} state_t;

    // One extra bit so the range check stays correct when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           fill_addr_q, fill_addr_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] mem_d [DEPTH];
    logic signed [WIDTH-1:0] rdata_q, rdata_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    init_done_q, init_done_d;
    logic                    drop_err_q, drop_err_d;
    logic                    waddr_ok, raddr_ok;
    logic                    lfsr_fb;

    assign waddr_ok = ({1'b0, waddr} < DEPTH_X);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_X);
    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Next-state, memory update and output computation.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        lfsr_d      = lfsr_q;
        mem_d       = mem_q;
        rdata_d     = rdata_q;
        rd_valid_d  = 1'b0;
        init_done_d = 1'b0;
        drop_err_d  = drop_err_q;

        case (state_q)
            IDLE: begin
                if (init_start) begin
                    // init_start wins; any access in the same cycle is lost.
                    state_d     = FILL;
                    fill_addr_d = '0;
                    if (we || re) drop_err_d = 1'b1;
                end else begin
                    // Read samples mem_q, so a same-address write returns the old word.
                    if (re) begin
                        rd_valid_d = 1'b1;
                        if (raddr_ok) begin
                            rdata_d = mem_q[raddr];
                        end else begin
                            rdata_d    = '0;
                            drop_err_d = 1'b1;
                        end
                    end
                    if (we) begin
                        if (waddr_ok) mem_d[waddr] = wdata;
                        else          drop_err_d   = 1'b1;
                    end
                end
            end
            FILL: begin
                mem_d[fill_addr_q] = lfsr_q[WIDTH-1:0];
                lfsr_d             = {lfsr_fb, lfsr_q[15:1]};
                fill_addr_d        = fill_addr_q + 1'b1;
                if (fill_addr_q == LAST_ADDR) begin
                    state_d     = IDLE;
                    fill_addr_d = '0;
                    init_done_d = 1'b1;
                end
                if (init_start || we || re) drop_err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, memory and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            lfsr_q      <= SEED;
            mem_q       <= '{default: '0};
            rdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            lfsr_q      <= lfsr_d;
            mem_q       <= mem_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            init_done_q <= init_done_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign rdata     = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = (state_q == FILL);
    assign init_done = init_done_q;
    assign drop_err  = drop_err_q;

endmodule

// File: doc/weight_bank.md
WEIGHT_BANK -- requirements
Module: weight_bank

Interface
REQ-001 Parameter WIDTH, default 10, weight word width, signed two's complement.
REQ-002 Parameter N_IN, default 30, input neurons.
REQ-003 Parameter N_HID, default 5, hidden neurons.
REQ-004 Parameter N_OUT, default 3, output neurons.
REQ-005 Parameter SEED, default 16'hACE1, LFSR reload value, nonzero.
REQ-006 Derived constants:
- DEPTH = N_IN*N_HID + N_HID*N_OUT (default 165).
- AW = clog2(DEPTH) (default 8).
REQ-007 Clock  input  1  single clock, all logic on rising edge.
REQ-008 Rst  input  1  synchronous, active-high reset.
REQ-009 init_start  input  1  one-cycle pulse, starts random fill of all weights.
REQ-010 we  input  1  single-word write enable.
REQ-011 waddr  input  AW  write address.
REQ-012 wdata  input  WIDTH  signed write data.
REQ-013 re  input  1  single-word read enable.
REQ-014 raddr  input  AW  read address.
REQ-015 rdata  output  WIDTH  signed read data, registered.
REQ-016 rd_valid  output  1  rdata valid, one-cycle pulse per accepted read.
REQ-017 busy  output  1  high while random fill in progress.
REQ-018 init_done  output  1  one-cycle pulse after last fill write.
REQ-019 drop_err  output  1  sticky; set when an access is dropped or out of range.

Function
REQ-020 Storage: DEPTH words of WIDTH bits.
- Addresses 0..N_IN*N_HID-1 hold input->hidden weights, indexed hid*N_IN+in.
- Remaining addresses hold hidden->output weights, indexed N_IN*N_HID + out*N_HID + hid.
REQ-021 FSM states: IDLE, FILL.
- IDLE -> FILL on init_start.
- FILL -> IDLE in the cycle the write to address DEPTH-1 occurs.
REQ-022 In FILL, the block writes one word per cycle to addresses 0,1,...,DEPTH-1 in order; the fill takes exactly DEPTH cycles.
REQ-023 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
- Each fill write stores LFSR[WIDTH-1:0], then steps the LFSR once.
- The LFSR steps only during FILL.
REQ-024 The LFSR reloads SEED only on Rst and is not reloaded by init_start, so successive fills differ.
REQ-025 busy is high in the cycle after init_start and stays high for DEPTH cycles; it is low in IDLE.
REQ-026 init_done pulses in the cycle after the final fill write, coincident with busy falling.
REQ-027 init_start while busy is ignored and sets drop_err.
REQ-028 Write in IDLE: we=1 with waddr<DEPTH stores wdata at waddr at the clock edge.
REQ-029 Read in IDLE: re=1 with raddr<DEPTH presents REGISTER[raddr] on rdata with rd_valid=1 in the next cycle (latency 1).
REQ-030 rdata holds its last value when rd_valid=0.
REQ-031 Simultaneous we and re to the same address: read-before-write; rdata returns the old word.
REQ-032 Out-of-range write (waddr>=DEPTH): no memory change; sets drop_err.
REQ-033 Out-of-range read (raddr>=DEPTH): rdata=0 and rd_valid=1 next cycle; sets drop_err.
REQ-034 we or re while busy, or in the cycle of init_start: the access is dropped, rd_valid stays 0, and drop_err is set.
REQ-035 init_start has priority over we and re presented in the same cycle.
REQ-036 drop_err clears only on Rst.

Reset
REQ-037 Rst=1 at a clock edge:
- All DEPTH words are set to 0.
- FSM goes to IDLE; LFSR is loaded with SEED.
- Outputs: rdata=0, rd_valid=0, busy=0, init_done=0, drop_err=0.
REQ-038 Rst has priority over all other inputs; Rst during FILL aborts the fill and leaves all words at 0.
REQ-039 The first init_start after Rst writes SEED[WIDTH-1:0] (10'h0E1 at defaults) to address 0.

Verification
REQ-040 Reset, then read addresses 0, 82, 164: three rd_valid pulses, each with rdata=0, drop_err=0.
REQ-041 Write 10'sh1FF to addr 7, then read addr 7 on the next cycle: rdata=10'sh1FF one cycle after re.
REQ-042 Pulse init_start: busy high for exactly 165 cycles, then init_done pulses. Read addr 0 -> 10'h0E1; read every address against a reference LFSR model -> all match.
REQ-043 Issue we to addr 3 and re at cycle 50 of the fill: the write is dropped, rd_valid stays 0, drop_err=1, and addr 3 holds its LFSR value after the fill.
REQ-044 Read addr 200: rdata=0, rd_valid=1, drop_err=1. Write addr 170: memory unchanged.
REQ-045 Assert Rst at fill cycle 100, then read addr 50: rdata=0, busy=0. A new init_start rewrites addr 0 with 10'h0E1.
